stream_sort: RTL and testbench

STREAM_SORT -- requirements
Module: stream_sort

---
 rtl/sort_pkg.sv | 13 +
 rtl/cmp_swap.sv | 17 +
 rtl/stream_sort.sv | 109 ++++++++++
 tb/tb_stream_sort.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared types and default sizing for the block sorter.
package sort_pkg;

    localparam int unsigned DefDim   = 4;
    localparam int unsigned DefWidth = 8;

    typedef enum logic [1:0] {
        LOAD,
        SORT,
        DRAIN
    } state_e;

endpackage

// File: rtl/cmp_swap.sv
// Combinational compare-exchange: the smaller unsigned operand goes to lo; ties keep order.
module cmp_swap #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    logic swap;

    assign swap = (b < a);
    assign lo   = swap ? b : a;
    assign hi   = swap ? a : b;

endmodule

// File: rtl/stream_sort.sv
// Collects a block of DIM elements, sorts it in place with odd-even transposition
// (one pass per cycle), then streams it out with valid/ready handshaking.
module stream_sort
    import sort_pkg::*;
#(
    parameter int unsigned DIM   = DefDim,
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int unsigned     CntW    = $clog2(DIM);
    localparam logic [CntW-1:0] LastIdx = CntW'(DIM - 1);

    state_e            state_q;
    logic [CntW-1:0]   load_cnt_q;
    logic [CntW-1:0]   pass_cnt_q;
    logic [CntW-1:0]   out_idx_q;
    logic [WIDTH-1:0]  buf_q  [DIM];
    logic [WIDTH-1:0]  sort_d [DIM];
    logic [WIDTH-1:0]  lo_w   [DIM-1];
    logic [WIDTH-1:0]  hi_w   [DIM-1];

    for (genvar g = 0; g < DIM - 1; g++) begin : g_cs
        cmp_swap #(
            .WIDTH(WIDTH)
        ) u_cmp_swap (
            .a (buf_q[g]),
            .b (buf_q[g+1]),
            .lo(lo_w[g]),
            .hi(hi_w[g])
        );
    end

    // Each slot takes lo of pair k or hi of pair k-1, whichever pair the pass parity enables.
    for (genvar k = 0; k < DIM; k++) begin : g_next
        localparam bit KOdd = (k % 2) == 1;
        if (k == 0) begin : g_first
            assign sort_d[k] = (pass_cnt_q[0] == KOdd) ? lo_w[k] : buf_q[k];
        end else if (k == DIM - 1) begin : g_last
            assign sort_d[k] = (pass_cnt_q[0] != KOdd) ? hi_w[k-1] : buf_q[k];
        end else begin : g_mid
            assign sort_d[k] = (pass_cnt_q[0] == KOdd) ? lo_w[k] : hi_w[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOAD;
            load_cnt_q <= '0;
            pass_cnt_q <= '0;
            out_idx_q  <= '0;
            buf_q      <= '{default: '0};
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_valid) begin
                        buf_q[load_cnt_q] <= in_data;
                        if (load_cnt_q == LastIdx) begin
                            load_cnt_q <= '0;
                            pass_cnt_q <= '0;
                            state_q    <= SORT;
                        end else begin
                            load_cnt_q <= load_cnt_q + 1'b1;
                        end
                    end
                end
                SORT: begin
                    buf_q <= sort_d;
                    if (pass_cnt_q == LastIdx) begin
                        pass_cnt_q <= '0;
                        out_idx_q  <= '0;
                        state_q    <= DRAIN;
                    end else begin
                        pass_cnt_q <= pass_cnt_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_idx_q == LastIdx) begin
                            out_idx_q  <= '0;
                            load_cnt_q <= '0;
                            state_q    <= LOAD;
                        end else begin
                            out_idx_q <= out_idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign busy      = (state_q != LOAD);
    assign out_valid = (state_q == DRAIN);
    assign out_last  = out_valid && (out_idx_q == LastIdx);
    assign out_data  = out_valid ? buf_q[out_idx_q] : '0;

endmodule

// File: tb/tb_stream_sort.sv
// Directed and randomized checks of stream_sort with DIM=4, WIDTH=8.
module tb_stream_sort;

    typedef logic [7:0] blk_t [4];
    typedef struct {
        blk_t din;
        blk_t dexp;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    int checks;
    int failures;
    int cyc;

    stream_sort #(
        .DIM  (4),
        .WIDTH(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Offers the block element by element; hs_cyc is the cycle count before the last accepting edge.
    task automatic send_block(input blk_t d, input int gap_pct, output int hs_cyc);
        int guard;
        hs_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_data  = d[k];
            guard    = 0;
            while (!in_ready && guard < 200) begin
                tick();
                guard++;
            end
            if (guard >= 200) check("send_timeout", 1, 0);
            hs_cyc = cyc;
            tick();
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic recv_block(input int ready_pct, output blk_t got, output logic [3:0] lasts);
        int k;
        int guard;
        k     = 0;
        guard = 0;
        got   = '{default: 8'h00};
        lasts = 4'b0000;
        while (k < 4 && guard < 500) begin
            out_ready = (int'($urandom_range(99)) < ready_pct);
            if (out_valid && out_ready) begin
                got[k]   = out_data;
                lasts[k] = out_last;
                if (k == 3) check("no_in_ready_on_last_out", {31'd0, in_ready}, 0);
                k++;
            end
            tick();
            guard++;
        end
        out_ready = 1'b0;
        if (k < 4) check("recv_timeout", k, 4);
    endtask

    task automatic check_block(input string name, input blk_t got, input logic [3:0] lasts,
                               input blk_t exp);
        for (int k = 0; k < 4; k++) check($sformatf("%s_data%0d", name, k), got[k], exp[k]);
        check($sformatf("%s_last", name), {28'd0, lasts}, 32'h8);
    endtask

    task automatic sort_ref(input blk_t d, output blk_t s);
        logic [7:0] t;
        s = d;
        for (int i = 1; i < 4; i++) begin
            for (int j = i; j > 0; j--) begin
                if (s[j] < s[j-1]) begin
                    t      = s[j];
                    s[j]   = s[j-1];
                    s[j-1] = t;
                end
            end
        end
    endtask

    vec_t       tbl [7];
    blk_t       got;
    blk_t       exp;
    blk_t       din;
    logic [3:0] lasts;
    int         hs;
    int         guard;
    bit         in_rdy_seen;

    initial begin
        tbl[0].din = '{8'd9, 8'd3, 8'd7, 8'd1};     tbl[0].dexp = '{8'd1, 8'd3, 8'd7, 8'd9};
        tbl[1].din = '{8'd255, 8'd0, 8'd255, 8'd0}; tbl[1].dexp = '{8'd0, 8'd0, 8'd255, 8'd255};
        tbl[2].din = '{8'd4, 8'd3, 8'd2, 8'd1};     tbl[2].dexp = '{8'd1, 8'd2, 8'd3, 8'd4};
        tbl[3].din = '{8'd1, 8'd2, 8'd3, 8'd4};     tbl[3].dexp = '{8'd1, 8'd2, 8'd3, 8'd4};
        tbl[4].din = '{8'd5, 8'd5, 8'd5, 8'd5};     tbl[4].dexp = '{8'd5, 8'd5, 8'd5, 8'd5};
        tbl[5].din = '{8'd0, 8'd128, 8'd127, 8'd1}; tbl[5].dexp = '{8'd0, 8'd1, 8'd127, 8'd128};
        tbl[6].din = '{8'd200, 8'd100, 8'd50, 8'd25}; tbl[6].dexp = '{8'd25, 8'd50, 8'd100, 8'd200};

        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 1);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_last", {31'd0, out_last}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_out_data", {24'd0, out_data}, 0);

        // Table vectors with out_ready high: data, last flag, latency and SORT-phase outputs.
        for (int v = 0; v < 7; v++) begin
            send_block(tbl[v].din, 0, hs);
            check($sformatf("v%0d_sort_busy", v), {31'd0, busy}, 1);
            check($sformatf("v%0d_sort_in_ready", v), {31'd0, in_ready}, 0);
            check($sformatf("v%0d_sort_out_data", v), {24'd0, out_data}, 0);
            guard = 0;
            while (!out_valid && guard < 50) begin
                tick();
                guard++;
            end
            check($sformatf("v%0d_latency", v), cyc - hs, 5);
            recv_block(100, got, lasts);
            check_block($sformatf("v%0d", v), got, lasts, tbl[v].dexp);
            check($sformatf("v%0d_in_ready_after", v), {31'd0, in_ready}, 1);
        end

        // Backpressure holds the first sorted element for 10 cycles.
        send_block(tbl[2].din, 0, hs);
        guard = 0;
        while (!out_valid && guard < 50) begin
            tick();
            guard++;
        end
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", {31'd0, out_valid}, 1);
            check("bp_data", {24'd0, out_data}, 1);
            check("bp_last", {31'd0, out_last}, 0);
            tick();
        end
        recv_block(100, got, lasts);
        check_block("bp", got, lasts, tbl[2].dexp);

        // Reset after two of four inputs discards the partial block.
        din = '{8'd5, 8'd6, 8'd0, 8'd0};
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = din[k];
            tick();
        end
        in_valid = 1'b0;
        do_reset();
        din = '{8'd8, 8'd2, 8'd6, 8'd4};
        exp = '{8'd2, 8'd4, 8'd6, 8'd8};
        send_block(din, 0, hs);
        recv_block(100, got, lasts);
        check_block("rst_load", got, lasts, exp);

        // Reset during SORT and during DRAIN.
        send_block(tbl[6].din, 0, hs);
        tick();
        do_reset();
        check("rst_sort_busy", {31'd0, busy}, 0);
        check("rst_sort_in_ready", {31'd0, in_ready}, 1);
        send_block(tbl[0].din, 0, hs);
        guard = 0;
        while (!out_valid && guard < 50) begin
            tick();
            guard++;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        do_reset();
        check("rst_drain_valid", {31'd0, out_valid}, 0);
        check("rst_drain_last", {31'd0, out_last}, 0);
        send_block(tbl[1].din, 0, hs);
        recv_block(100, got, lasts);
        check_block("after_rst", got, lasts, tbl[1].dexp);

        // in_valid held high with 0xAA through SORT and DRAIN must be ignored.
        din = '{8'd40, 8'd10, 8'd30, 8'd20};
        exp = '{8'd10, 8'd20, 8'd30, 8'd40};
        send_block(din, 0, hs);
        in_valid    = 1'b1;
        in_data     = 8'hAA;
        in_rdy_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (in_ready) in_rdy_seen = 1'b1;
            tick();
        end
        recv_block(100, got, lasts);
        in_valid = 1'b0;
        in_data  = 8'h00;
        check("aa_no_accept", {31'd0, in_rdy_seen}, 0);
        check_block("aa", got, lasts, exp);
        din = '{8'd3, 8'd1, 8'd2, 8'd0};
        exp = '{8'd0, 8'd1, 8'd2, 8'd3};
        send_block(din, 0, hs);
        recv_block(100, got, lasts);
        check_block("aa_next", got, lasts, exp);

        // Random blocks with input gaps and output stalls against a reference sort.
        for (int b = 0; b < 1000; b++) begin
            for (int k = 0; k < 4; k++) din[k] = 8'($urandom_range(255));
            sort_ref(din, exp);
            send_block(din, 30, hs);
            recv_block(60, got, lasts);
            check_block($sformatf("rnd%0d", b), got, lasts, exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
